// File: rtl/seq_hit_monitor_if.sv
// Hit input, clear and status outputs of the hit monitor as one bundle.
// master drives hit/clr and observes status; slave is the monitor itself.
interface seq_hit_monitor_if #(
  parameter int CNT_W = 16,
  parameter int GAP_W = 8
);
  logic             hit;
  logic             clr;
  logic [CNT_W-1:0] hit_count;
  logic [GAP_W-1:0] last_gap;
  logic             gap_valid;
  logic             burst_alarm;
  logic             alarm_pulse;
  logic [1:0]       state_o;

  modport master (
    output hit, clr,
    input  hit_count, last_gap, gap_valid, burst_alarm, alarm_pulse, state_o
  );

  modport slave (
    input  hit, clr,
    output hit_count, last_gap, gap_valid, burst_alarm, alarm_pulse, state_o
  );
endinterface

// File: rtl/seq_hit_monitor.sv
// Counts single-cycle detector hits, measures inter-hit gap, raises a sticky burst alarm.
// Latency 1 cycle (all outputs registered); no backpressure, every hit is sampled.
module seq_hit_monitor #(
  parameter int CNT_W   = 16,
  parameter int GAP_W   = 8,
  parameter int BURST_N = 4,
  parameter int WINDOW  = 16
) (
  input  logic             clk,
  input  logic             reset,
  seq_hit_monitor_if.slave mon
);

  generate
    if (BURST_N < 2 || BURST_N > WINDOW || WINDOW < 2) begin : g_param_check
      $error("seq_hit_monitor: illegal BURST_N/WINDOW combination");
    end
  endgenerate

  localparam int WC_W = $clog2(WINDOW);
  localparam int BC_W = $clog2(BURST_N + 1);
  localparam logic [WC_W-1:0]  WC_LAST = WC_W'(WINDOW - 1);
  localparam logic [BC_W-1:0]  BC_LAST = BC_W'(BURST_N - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [GAP_W-1:0] GAP_MAX = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WIN   = 2'd1,
    ALARM = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [WC_W-1:0]  wcnt, wcnt_n;
  logic [BC_W-1:0]  bcnt, bcnt_n;
  logic             alarm_rise;

  logic [CNT_W-1:0] hit_count;
  logic [GAP_W-1:0] last_gap;
  logic [GAP_W-1:0] gap_cnt;
  logic             gap_valid;
  logic             burst_alarm;
  logic             alarm_pulse;
  logic             seen;

  // hit_count only returns to zero on reset/clr, so it doubles as "first hit seen"
  assign seen = (hit_count != '0);

  always_ff @(posedge clk) begin
    if (reset || mon.clr) begin
      state <= IDLE;
      wcnt  <= '0;
      bcnt  <= '0;
    end else begin
      state <= state_n;
      wcnt  <= wcnt_n;
      bcnt  <= bcnt_n;
    end
  end

  always_comb begin
    state_n = state;
    wcnt_n  = wcnt;
    bcnt_n  = bcnt;
    case (state)
      IDLE: begin
        if (mon.hit) begin
          state_n = WIN;
          wcnt_n  = WC_W'(1);
          bcnt_n  = BC_W'(1);
        end
      end
      WIN: begin
        if (mon.hit && bcnt == BC_LAST) begin
          state_n = ALARM;
        end else if (wcnt == WC_LAST) begin
          // a hit on the closing cycle neither counts toward nor opens a window
          state_n = IDLE;
          wcnt_n  = '0;
          bcnt_n  = '0;
        end else begin
          wcnt_n = wcnt + 1'b1;
          bcnt_n = bcnt + BC_W'(mon.hit);
        end
      end
      default: begin
      end
    endcase
  end

  assign alarm_rise = (state != ALARM) && (state_n == ALARM);

  always_ff @(posedge clk) begin
    if (reset || mon.clr) begin
      hit_count   <= '0;
      last_gap    <= '0;
      gap_cnt     <= '0;
      gap_valid   <= 1'b0;
      burst_alarm <= 1'b0;
      alarm_pulse <= 1'b0;
    end else begin
      alarm_pulse <= alarm_rise;
      if (alarm_rise) begin
        burst_alarm <= 1'b1;
      end
      if (mon.hit) begin
        if (hit_count != CNT_MAX) begin
          hit_count <= hit_count + 1'b1;
        end
        gap_cnt <= GAP_W'(1);
        if (seen) begin
          last_gap  <= gap_cnt;
          gap_valid <= 1'b1;
        end
      end else if (seen && gap_cnt != GAP_MAX) begin
        gap_cnt <= gap_cnt + 1'b1;
      end
    end
  end

  assign mon.hit_count   = hit_count;
  assign mon.last_gap    = last_gap;
  assign mon.gap_valid   = gap_valid;
  assign mon.burst_alarm = burst_alarm;
  assign mon.alarm_pulse = alarm_pulse;
  assign mon.state_o     = state;

endmodule

// File: tb/tb_seq_hit_monitor.sv
// Scoreboard bench for seq_hit_monitor: three configurations driven with directed hit patterns.
// Expected status is queued per edge; a negedge monitor pops and compares.
module tb_seq_hit_monitor;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  seq_hit_monitor_if #(.CNT_W(16), .GAP_W(8)) if0 ();
  seq_hit_monitor_if #(.CNT_W(16), .GAP_W(8)) if1 ();
  seq_hit_monitor_if #(.CNT_W(3),  .GAP_W(3)) if2 ();

  seq_hit_monitor u0 (
    .clk   (clk),
    .reset (reset),
    .mon   (if0)
  );

  seq_hit_monitor #(.BURST_N(3), .WINDOW(8)) u1 (
    .clk   (clk),
    .reset (reset),
    .mon   (if1)
  );

  seq_hit_monitor #(.CNT_W(3), .GAP_W(3)) u2 (
    .clk   (clk),
    .reset (reset),
    .mon   (if2)
  );

  typedef struct {
    int          id;
    int          cyc;
    string       tag;
    logic [15:0] cnt;
    logic [7:0]  gap;
    logic        gv;
    logic        ba;
    logic        ap;
    logic [1:0]  st;
  } exp_t;

  exp_t sbq[$];
  int   edge_n = 0;
  int   total  = 0;
  int   bad    = 0;

  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic set_in(input int id, input logic h, input logic c);
    case (id)
      0:       begin if0.hit = h; if0.clr = c; end
      1:       begin if1.hit = h; if1.clr = c; end
      default: begin if2.hit = h; if2.clr = c; end
    endcase
  endtask

  task automatic expect_o(input int id, input string tag, input int cnt, input int gap,
                          input logic gv, input logic ba, input logic ap, input int st);
    exp_t e;
    e.id  = id;
    e.cyc = edge_n;
    e.tag = tag;
    e.cnt = 16'(cnt);
    e.gap = 8'(gap);
    e.gv  = gv;
    e.ba  = ba;
    e.ap  = ap;
    e.st  = 2'(st);
    sbq.push_back(e);
  endtask

  // drive one cycle of hit/clr to one DUT, then queue the expected status after that edge
  task automatic drive(input int id, input logic h, input logic c);
    set_in(id, h, c);
    @(posedge clk);
    #1;
    set_in(id, 1'b0, 1'b0);
  endtask

  task automatic step(input int id, input string tag, input logic h, input logic c,
                      input int cnt, input int gap, input logic gv, input logic ba,
                      input logic ap, input int st);
    drive(id, h, c);
    expect_o(id, tag, cnt, gap, gv, ba, ap, st);
  endtask

  task automatic idle(input int id, input int n);
    repeat (n) drive(id, 1'b0, 1'b0);
  endtask

  task automatic check_pending();
    exp_t        e;
    logic [15:0] a_cnt;
    logic [7:0]  a_gap;
    logic        a_gv, a_ba, a_ap;
    logic [1:0]  a_st;
    while (sbq.size() > 0 && sbq[0].cyc <= edge_n) begin
      e = sbq.pop_front();
      case (e.id)
        0: begin
          a_cnt = if0.hit_count; a_gap = if0.last_gap; a_gv = if0.gap_valid;
          a_ba = if0.burst_alarm; a_ap = if0.alarm_pulse; a_st = if0.state_o;
        end
        1: begin
          a_cnt = if1.hit_count; a_gap = if1.last_gap; a_gv = if1.gap_valid;
          a_ba = if1.burst_alarm; a_ap = if1.alarm_pulse; a_st = if1.state_o;
        end
        default: begin
          a_cnt = 16'(if2.hit_count); a_gap = 8'(if2.last_gap); a_gv = if2.gap_valid;
          a_ba = if2.burst_alarm; a_ap = if2.alarm_pulse; a_st = if2.state_o;
        end
      endcase
      total++;
      if (e.cyc != edge_n || a_cnt !== e.cnt || a_gap !== e.gap || a_gv !== e.gv ||
          a_ba !== e.ba || a_ap !== e.ap || a_st !== e.st) begin
        bad++;
        $display("FAIL %s (dut%0d edge %0d, checked at %0d): got cnt=%0d gap=%0d gv=%b ba=%b ap=%b st=%0d, want cnt=%0d gap=%0d gv=%b ba=%b ap=%b st=%0d",
                 e.tag, e.id, e.cyc, edge_n, a_cnt, a_gap, a_gv, a_ba, a_ap, a_st,
                 e.cnt, e.gap, e.gv, e.ba, e.ap, e.st);
      end
    end
  endtask

  always @(negedge clk) check_pending();

  initial begin
    if0.hit = 1'b1; if0.clr = 1'b0;
    if1.hit = 1'b1; if1.clr = 1'b0;
    if2.hit = 1'b1; if2.clr = 1'b0;
    reset = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      for (int id = 0; id < 3; id++) expect_o(id, "reset with hit", 0, 0, 0, 0, 0, 0);
    end
    reset = 1'b0;
    for (int id = 0; id < 3; id++) set_in(id, 1'b0, 1'b0);

    // defaults: hits at 10, 13, 20, then back-to-back at 21 completes a 4-hit burst
    idle(0, 10);
    step(0, "A hit10",         1, 0, 1, 0, 0, 0, 0, 1);
    idle(0, 2);
    step(0, "A hit13",         1, 0, 2, 3, 1, 0, 0, 1);
    idle(0, 6);
    step(0, "A hit20",         1, 0, 3, 7, 1, 0, 0, 1);
    step(0, "A hit21 burst",   1, 0, 4, 1, 1, 1, 1, 2);
    step(0, "A pulse drops",   0, 0, 4, 1, 1, 1, 0, 2);
    step(0, "A clr",           0, 1, 0, 0, 0, 0, 0, 0);

    // BURST_N=3 WINDOW=8: hits 0,2,4 alarm; hit 6 no re-pulse; clr with hit
    step(1, "B hit0",          1, 0, 1, 0, 0, 0, 0, 1);
    idle(1, 1);
    step(1, "B hit2",          1, 0, 2, 2, 1, 0, 0, 1);
    idle(1, 1);
    step(1, "B hit4 alarm",    1, 0, 3, 2, 1, 1, 1, 2);
    step(1, "B after alarm",   0, 0, 3, 2, 1, 1, 0, 2);
    step(1, "B hit6 sticky",   1, 0, 4, 2, 1, 1, 0, 2);
    step(1, "B clr with hit",  1, 1, 0, 0, 0, 0, 0, 0);
    step(1, "B idle post clr", 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, "B first hit",     1, 0, 1, 0, 0, 0, 0, 1);
    step(1, "B clr",           0, 1, 0, 0, 0, 0, 0, 0);

    // hits 0,2,9,11,13: first window expires after cycle 7
    step(1, "C hit0",          1, 0, 1, 0, 0, 0, 0, 1);
    idle(1, 1);
    step(1, "C hit2",          1, 0, 2, 2, 1, 0, 0, 1);
    idle(1, 3);
    step(1, "C cycle6 open",   0, 0, 2, 2, 1, 0, 0, 1);
    step(1, "C cycle7 close",  0, 0, 2, 2, 1, 0, 0, 0);
    idle(1, 1);
    step(1, "C hit9 reopen",   1, 0, 3, 7, 1, 0, 0, 1);
    idle(1, 1);
    step(1, "C hit11",         1, 0, 4, 2, 1, 0, 0, 1);
    idle(1, 1);
    step(1, "C hit13 alarm",   1, 0, 5, 2, 1, 1, 1, 2);
    step(1, "C clr",           0, 1, 0, 0, 0, 0, 0, 0);

    // hit on the closing cycle is discarded for bursting and opens nothing
    step(1, "D hit0",          1, 0, 1, 0, 0, 0, 0, 1);
    idle(1, 6);
    step(1, "D hit7 closing",  1, 0, 2, 7, 1, 0, 0, 0);
    step(1, "D hit8 opens",    1, 0, 3, 1, 1, 0, 0, 1);
    step(1, "D hit9",          1, 0, 4, 1, 1, 0, 0, 1);
    step(1, "D hit10 alarm",   1, 0, 5, 1, 1, 1, 1, 2);

    // CNT_W=3 GAP_W=3: nine hits 10 cycles apart saturate both counters
    for (int i = 0; i < 9; i++) begin
      if (i > 0) idle(2, 9);
      step(2, "E saturation", 1, 0, (i + 1 > 7) ? 7 : i + 1, (i == 0) ? 0 : 7,
           (i > 0), 0, 0, 1);
    end

    idle(2, 3);
    if (sbq.size() != 0) begin
      $display("FAIL scoreboard drain: got %0d unchecked entries, want 0", sbq.size());
      bad += sbq.size();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
